// File: rtl/fp_scan_pkg.sv
// Shared definitions for the front-panel matrix scan sequencer.
// Holds the scan FSM state enum, the default parameter values and a helper
// that sizes index/counter fields so that width-1 cases stay legal.
package fp_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT_LO,
    SHIFT_HI,
    EVAL,
    EMIT
  } scan_state_e;

  localparam int DEF_SCAN_BITS      = 64;
  localparam int DEF_CLK_DIV        = 50;
  localparam int DEF_SCAN_INTERVAL  = 1000000;
  localparam int DEF_DEBOUNCE_SCANS = 3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_matrix_scan_sequencer_if.sv
// Key-event channel of the scan sequencer.
//   evt_valid   - an event is presented (producer)
//   evt_ready   - consumer accepts the event
//   evt_index   - index of the key that changed
//   evt_pressed - new level of that key
//   INT_OUT     - interrupt line, mirrors evt_valid
interface fp_matrix_scan_sequencer_if #(
  parameter int SCAN_BITS = fp_scan_pkg::DEF_SCAN_BITS
) ();
  localparam int IDX_W = fp_scan_pkg::idx_w(SCAN_BITS);

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_index;
  logic             evt_pressed;
  logic             INT_OUT;

  modport master (output evt_valid, evt_index, evt_pressed, INT_OUT, input evt_ready);
  modport slave  (input evt_valid, evt_index, evt_pressed, INT_OUT, output evt_ready);
endinterface

// File: rtl/fp_lsb_encoder.sv
// Lowest-set-bit priority encoder.
//   vec   - input bit vector (SCAN_BITS wide)
//   index - position of the lowest set bit (0 when vec is empty)
//   any   - vec has at least one bit set
module fp_lsb_encoder
  import fp_scan_pkg::*;
#(
  parameter int SCAN_BITS = DEF_SCAN_BITS,
  parameter int IDX_W     = idx_w(SCAN_BITS)
) (
  input  logic [SCAN_BITS-1:0] vec,
  output logic [IDX_W-1:0]     index,
  output logic                 any
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = SCAN_BITS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_matrix_scan_sequencer.sv
// Front-panel key matrix scan sequencer.
// Periodically pulses MATRIX_CLEAR to latch the key chain, shifts SCAN_BITS
// bits in (bit 0 first) with MATRIX_CLOCK, debounces whole frames and emits
// one event per changed key, lowest index first.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET - clock, synchronous active-high reset
//   enable                   - scans may start while high
//   MATRIX_CLEAR/CLOCK       - strobes to the external shift chain
//   MATRIX_DATA_IN           - serial data from the chain
//   key_state                - debounced key vector (1 = pressed)
//   evt_if                   - key-event channel (valid/ready + INT_OUT)
module fp_matrix_scan_sequencer
  import fp_scan_pkg::*;
#(
  parameter int SCAN_BITS      = DEF_SCAN_BITS,
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int SCAN_INTERVAL  = DEF_SCAN_INTERVAL,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  enable,
  output logic                  MATRIX_CLEAR,
  output logic                  MATRIX_CLOCK,
  input  logic                  MATRIX_DATA_IN,
  output logic [SCAN_BITS-1:0]  key_state,
  fp_matrix_scan_sequencer_if.master evt_if
);

  localparam int IDX_W   = idx_w(SCAN_BITS);
  localparam int DIV_W   = idx_w(CLK_DIV);
  localparam int IVL_W   = idx_w(SCAN_INTERVAL);
  localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

  scan_state_e          state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     bit_q, bit_d;
  logic [IVL_W-1:0]     ivl_q, ivl_d;
  logic                 req_q, req_d;
  logic                 first_q, first_d;
  logic [SCAN_BITS-1:0] raw_q, raw_d;
  logic [SCAN_BITS-1:0] prev_q, prev_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [SCAN_BITS-1:0] key_q, key_d;
  logic [SCAN_BITS-1:0] mask_q, mask_d;

  logic             wrap, req_now, start, div_last, bit_last;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             evt_valid;

  fp_lsb_encoder #(.SCAN_BITS(SCAN_BITS), .IDX_W(IDX_W)) u_enc (
    .vec   (mask_q),
    .index (enc_idx),
    .any   (enc_any)
  );

  // Strobes decode straight from the state register so their lengths are
  // exactly the time spent in the corresponding state.
  assign MATRIX_CLEAR = (state_q == CLEAR);
  assign MATRIX_CLOCK = (state_q == SHIFT_HI);
  assign key_state    = key_q;

  assign evt_valid          = (state_q == EMIT) && enc_any;
  assign evt_if.evt_valid   = evt_valid;
  assign evt_if.INT_OUT     = evt_valid;
  assign evt_if.evt_index   = enc_idx;
  assign evt_if.evt_pressed = key_q[enc_idx];

  // Request generation: free-running interval wrap plus a one-shot on the
  // first enabled cycle after reset. The pending flag is one deep, so extra
  // wraps while a scan cannot start simply merge into it.
  always_comb begin
    wrap    = (ivl_q == IVL_W'(SCAN_INTERVAL - 1));
    ivl_d   = wrap ? '0 : ivl_q + IVL_W'(1);
    req_now = wrap | (enable & ~first_q);
    first_d = first_q | enable;
    // IDLE already implies the pending-change mask is empty.
    start   = (state_q == IDLE) && enable && (req_q || req_now);
    req_d   = start ? 1'b0 : (req_q | req_now);
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    match_d  = match_q;
    key_d    = key_q;
    mask_d   = mask_q;
    div_last = (div_q == DIV_W'(CLK_DIV - 1));
    bit_last = (bit_q == IDX_W'(SCAN_BITS - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          div_d   = '0;
          bit_d   = '0;
          raw_d   = '0;
        end
      end
      CLEAR: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          raw_d[bit_q] = MATRIX_DATA_IN;
          div_d        = '0;
          state_d      = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        div_d = div_q + DIV_W'(1);
        if (div_last) begin
          div_d = '0;
          if (bit_last) begin
            state_d = EVAL;
          end else begin
            bit_d   = bit_q + IDX_W'(1);
            state_d = SHIFT_LO;
          end
        end
      end
      EVAL: begin
        if (raw_q == prev_q)
          match_d = (match_q >= MATCH_W'(DEBOUNCE_SCANS)) ? match_q : match_q + MATCH_W'(1);
        else
          match_d = MATCH_W'(1);
        prev_d  = raw_q;
        state_d = IDLE;
        if ((match_d == MATCH_W'(DEBOUNCE_SCANS)) && (raw_q != key_q)) begin
          key_d   = raw_q;
          mask_d  = raw_q ^ key_q;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Mask only changes on a handshake, so the presented event holds
        // still while the consumer stalls.
        if (evt_if.evt_ready) begin
          mask_d[enc_idx] = 1'b0;
          if (mask_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ivl_q   <= '0;
      req_q   <= 1'b0;
      first_q <= 1'b0;
      raw_q   <= '0;
      prev_q  <= '0;
      match_q <= '0;
      key_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ivl_q   <= ivl_d;
      req_q   <= req_d;
      first_q <= first_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_fp_matrix_scan_sequencer.sv
// Bench for fp_matrix_scan_sequencer: an external shift chain model feeds
// frames, a frame-level debounce model predicts key_state and events.
module tb_fp_matrix_scan_sequencer;
  localparam int SB = 8;
  localparam int CD = 2;
  localparam int SI = 100;
  localparam int DS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          mclr, mclk, mdata;
  logic [SB-1:0] key_state;

  fp_matrix_scan_sequencer_if #(.SCAN_BITS(SB)) evt_if ();

  fp_matrix_scan_sequencer #(
    .SCAN_BITS(SB), .CLK_DIV(CD), .SCAN_INTERVAL(SI), .DEBOUNCE_SCANS(DS)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESET   (rst),
    .enable         (enable),
    .MATRIX_CLEAR   (mclr),
    .MATRIX_CLOCK   (mclk),
    .MATRIX_DATA_IN (mdata),
    .key_state      (key_state),
    .evt_if         (evt_if)
  );

  always #5 clk = ~clk;

  // Parallel-load shift chain plus scan/event monitors.
  logic [SB-1:0] frame = '0;
  logic [SB-1:0] sh = '0;
  logic ck_prev = 1'b0, clr_prev = 1'b0;
  int   scan_starts = 0, clr_cycles = 0, pulses = 0, last_rise = 0, cyc = 0, rel = 0;
  bit   period_bad = 1'b0;
  int   ev_q[$];

  assign mdata = sh[0];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rel      <= rst ? 0 : rel + 1;
    ck_prev  <= mclk;
    clr_prev <= mclr;
    if (mclr) sh <= frame;
    else if (mclk && !ck_prev) sh <= sh >> 1;
    if (mclr && !clr_prev) begin
      scan_starts <= scan_starts + 1;
      clr_cycles  <= 1;
      pulses      <= 0;
      period_bad  <= 1'b0;
    end else if (mclr) begin
      clr_cycles <= clr_cycles + 1;
    end
    if (mclk && !ck_prev) begin
      pulses    <= pulses + 1;
      last_rise <= cyc;
      if (pulses > 0 && (cyc - last_rise) != 2 * CD) period_bad <= 1'b1;
    end
    if (evt_if.evt_valid && evt_if.evt_ready)
      ev_q.push_back(int'(evt_if.evt_index) * 2 + int'(evt_if.evt_pressed));
  end

  // Reference model: frame-level debounce.
  logic [SB-1:0] mprev = '0, mkey = '0;
  int mcnt = 0;
  int exp_q[$];
  int tests = 0, fails = 0;

  task automatic model_scan(input logic [SB-1:0] f);
    if (f == mprev) mcnt = (mcnt < DS) ? mcnt + 1 : DS;
    else            mcnt = 1;
    mprev = f;
    exp_q.delete();
    if (mcnt >= DS && f != mkey) begin
      for (int i = 0; i < SB; i++)
        if (f[i] != mkey[i]) exp_q.push_back(i * 2 + int'(f[i]));
      mkey = f;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_events(input string tag);
    chk({tag, ":ev_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
      chk({tag, ":ev"}, ev_q[i], exp_q[i]);
  endtask

  task automatic wait_start(input string tag, input int s0, input int budget);
    int k = 0;
    while (scan_starts == s0 && k < budget) begin tick(); k++; end
    chk({tag, ":start"}, scan_starts != s0, 1);
  endtask

  // Called one cycle after MATRIX_CLEAR rose; EVAL ends 34 cycles later.
  task automatic finish(input string tag, input logic [SB-1:0] f);
    model_scan(f);
    tick(34);
    chk({tag, ":clr_cycles"}, clr_cycles, CD);
    chk({tag, ":pulses"}, pulses, SB);
    chk({tag, ":period"}, period_bad, 0);
    chk({tag, ":key_state"}, key_state, mkey);
    if (evt_if.evt_ready) begin
      for (int k = 0; k < 20; k++) begin
        chk({tag, ":int_out"}, evt_if.INT_OUT, ev_q.size() < exp_q.size());
        if (ev_q.size() >= exp_q.size()) break;
        tick();
      end
      cmp_events(tag);
    end
  endtask

  task automatic run_scan(input string tag, input logic [SB-1:0] f);
    int s0;
    frame = f;
    s0 = scan_starts;
    ev_q.delete();
    wait_start(tag, s0, 250);
    finish(tag, f);
  endtask

  initial begin
    logic [SB-1:0] hx, f;
    logic [2:0]    hi;
    logic          hp;
    bit            stable;
    int            s0, k;

    evt_if.evt_ready = 1'b1;
    tick(3);
    chk("rst:clear", mclr, 0);
    chk("rst:clock", mclk, 0);
    chk("rst:key", key_state, 0);
    chk("rst:valid", evt_if.evt_valid, 0);
    chk("rst:int", evt_if.INT_OUT, 0);
    chk("rst:index", evt_if.evt_index, 0);
    chk("rst:pressed", evt_if.evt_pressed, 0);

    rst = 1'b0;
    enable = 1'b1;
    run_scan("zero", 8'h00);

    run_scan("once05", 8'h05);
    run_scan("back00", 8'h00);
    chk("glitch:key", key_state, 8'h00);

    run_scan("a05", 8'h05);
    run_scan("b05", 8'h05);
    chk("accept:key", key_state, 8'h05);
    chk("accept:n", exp_q.size(), 2);

    for (int r = 0; r < 12; r++) begin
      f = ($urandom_range(0, 1) == 0) ? mprev : SB'($urandom);
      run_scan("rand", f);
    end

    // Stalled consumer: event must hold and interval requests must merge.
    hx = ~mkey;
    if (hx == '0) hx = 8'h3C;
    run_scan("pre_hold", mkey);
    evt_if.evt_ready = 1'b0;
    run_scan("hold1", hx);
    run_scan("hold2", hx);
    chk("hold:valid", evt_if.evt_valid, 1);
    chk("hold:index", evt_if.evt_index, exp_q[0] >> 1);
    chk("hold:pressed", evt_if.evt_pressed, exp_q[0] & 1);
    s0 = scan_starts;
    hi = evt_if.evt_index;
    hp = evt_if.evt_pressed;
    stable = 1'b1;
    repeat (300) begin
      tick();
      if (!(evt_if.evt_valid && evt_if.evt_index == hi && evt_if.evt_pressed == hp)) stable = 1'b0;
    end
    chk("hold:stable", stable, 1);
    chk("hold:no_scan", scan_starts, s0);
    k = 0;
    while ((rel % SI) != 40 && k < SI) begin tick(); k++; end
    evt_if.evt_ready = 1'b1;
    k = 0;
    while (ev_q.size() < exp_q.size() && k < 20) begin tick(); k++; end
    cmp_events("hold_drain");
    ev_q.delete();
    wait_start("held", s0, 10);
    finish("held", hx);
    chk("held:single", scan_starts, s0 + 1);

    // Reset in the high phase of bit 4.
    s0 = scan_starts;
    wait_start("abort", s0, 250);
    k = 0;
    while (!(pulses == 5 && mclk) && k < 40) begin tick(); k++; end
    chk("abort:bit4_hi", pulses == 5 && mclk, 1);
    rst = 1'b1;
    tick();
    chk("abort:clear", mclr, 0);
    chk("abort:clock", mclk, 0);
    chk("abort:key", key_state, 0);
    chk("abort:valid", evt_if.evt_valid, 0);
    chk("abort:int", evt_if.INT_OUT, 0);
    chk("abort:index", evt_if.evt_index, 0);
    chk("abort:pressed", evt_if.evt_pressed, 0);
    rst = 1'b0;
    mprev = '0;
    mkey  = '0;
    mcnt  = 0;
    run_scan("post_rst", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_matrix_scan_sequencer.md
FP_MATRIX_SCAN_SEQUENCER -- requirements
Module: fp_matrix_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 64, the number of front-panel matrix bits shifted per scan.
REQ-002 SHALL have parameter CLK_DIV, default 50, the number of clock cycles per MATRIX_CLOCK half-period and per clear pulse (minimum 1).
REQ-003 SHALL have parameter SCAN_INTERVAL, default 1000000, the number of clock cycles from one scan start to the next (must be greater than the scan length).
REQ-004 SHALL have parameter DEBOUNCE_SCANS, default 3, the number of consecutive identical raw frames required before acceptance (minimum 1).
REQ-005 S_AXI_ACLK  in  1  single clock; all logic is clocked on its rising edge.
REQ-006 S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-007 enable  in  1  scanning is permitted while high.
REQ-008 MATRIX_CLEAR  out  1  latch/clear strobe to the shift chain.
REQ-009 MATRIX_CLOCK  out  1  shift clock to the chain.
REQ-010 MATRIX_DATA_IN  in  1  serial data from the chain.
REQ-011 key_state  out  SCAN_BITS  debounced key vector; bit i = 1 means key i is pressed.
REQ-012 evt_valid  out  1  a key event is presented.
REQ-013 evt_ready  in  1  consumer accepts the event.
REQ-014 evt_index  out  clog2(SCAN_BITS)  index of the changed key.
REQ-015 evt_pressed  out  1  new level of that key.
REQ-016 INT_OUT  out  1  interrupt; equals evt_valid.

Function
REQ-017 SHALL use FSM states IDLE, CLEAR, SHIFT_LO, SHIFT_HI, EVAL, EMIT.
REQ-018 Interval counter SHALL run freely; a scan request SHALL occur on counter wrap at SCAN_INTERVAL-1, and again on the first cycle enable is high after reset.
REQ-019 IDLE->CLEAR SHALL occur on a pending scan request only when enable=1 and no changes remain to emit; otherwise the request SHALL be held (one deep), not counted twice.
REQ-020 CLEAR SHALL drive MATRIX_CLEAR=1 for CLK_DIV cycles, then go to SHIFT_LO.
REQ-021 SHIFT_LO SHALL drive MATRIX_CLOCK=0 for CLK_DIV cycles; SHIFT_HI SHALL drive MATRIX_CLOCK=1 for CLK_DIV cycles.
REQ-022 MATRIX_DATA_IN SHALL be sampled on the last cycle of each SHIFT_LO; the first sample SHALL be bit 0.
REQ-023 After SCAN_BITS samples, the block SHALL go from SHIFT_HI to EVAL; scan length is CLK_DIV*(1+2*SCAN_BITS) cycles.
REQ-024 In EVAL (1 cycle): if the raw frame equals the previous raw frame, match_cnt SHALL increment, saturating at DEBOUNCE_SCANS; otherwise match_cnt SHALL be set to 1. The raw frame SHALL be stored as the previous frame.
REQ-025 In EVAL: when match_cnt reaches DEBOUNCE_SCANS and raw differs from key_state, key_state SHALL be updated to raw in the same cycle, the pending mask SHALL be set to raw XOR the old key_state, and the FSM SHALL go to EMIT; otherwise it SHALL go to IDLE.
REQ-026 EMIT SHALL present the lowest set bit of the pending mask, with evt_pressed = key_state of that bit.
REQ-027 On evt_valid and evt_ready, that bit SHALL be cleared and the next event SHALL be presented on the following cycle; EMIT->IDLE SHALL occur when the mask becomes empty.
REQ-028 While evt_valid=1 and evt_ready=0, evt_index and evt_pressed SHALL hold stable.
REQ-029 enable going low mid-scan SHALL let the current scan and emission complete; no new scan SHALL start.
REQ-030 DEBOUNCE_SCANS=1 SHALL accept every frame.

Reset
REQ-031 While S_AXI_ARESET=1: state=IDLE; MATRIX_CLEAR=0, MATRIX_CLOCK=0, key_state=0, evt_valid=0, INT_OUT=0, evt_index=0, evt_pressed=0; counters, previous frame, match_cnt, pending mask and request flag all cleared.
REQ-032 Reset asserted mid-scan or mid-emission SHALL abort it with no event emitted afterward.

Structure
REQ-033 Shared package fp_scan_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 The lowest-set-bit priority encoder SHALL be sub-module fp_lsb_encoder (SCAN_BITS wide, outputs index and any).

Verification (SCAN_BITS=8, CLK_DIV=2, SCAN_INTERVAL=100, DEBOUNCE_SCANS=2)
REQ-035 Enable after reset, data held 0 -> MATRIX_CLEAR high for 2 cycles, 8 MATRIX_CLOCK pulses of 4-cycle period, no events, key_state=0.
REQ-036 Chain returns 0x05 on two consecutive scans -> after the second EVAL, key_state=0x05; events (0,1) then (2,1); INT_OUT high until the second event is accepted.
REQ-037 Chain returns 0x05 for only one scan, then 0x00 -> no event, key_state stays 0.
REQ-038 evt_ready held low for 300 cycles with one event pending -> event stable, no new scan started, single held request serviced after acceptance.
REQ-039 S_AXI_ARESET pulsed during SHIFT_HI of bit 4 -> next cycle all outputs at reset values; the next full scan behaves as in REQ-035.
